// File: rtl/cpu_pkg.sv
// Shared CPU constants: fetch FSM states, MIPS opcode/funct encodings, NOP.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;

  localparam logic [31:0] NOP = 32'h0;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Avalon-MM read port between the fetch stage (master) and instruction memory (slave).
interface instruction_fetch_if;
    logic [31:0] avm_address;
    logic        avm_read;
    logic [3:0]  avm_byteenable;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    modport master (
        output avm_address, avm_read, avm_byteenable,
        input  avm_waitrequest, avm_readdata
    );

    modport slave (
        input  avm_address, avm_read, avm_byteenable,
        output avm_waitrequest, avm_readdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Multicycle MIPS fetch stage: reads the word at pc over Avalon, stalls the PC
// unit until it arrives, and exposes the decoded instruction fields.
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit ENDIAN_SWAP    = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         pc,
    input  logic                fetch_req,
    instruction_fetch_if.master avm,
    output logic                stall,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [5:0]          opcode,
    output logic [4:0]          rs,
    output logic [4:0]          rt,
    output logic [4:0]          rd,
    output logic [4:0]          shamt,
    output logic [5:0]          funct,
    output logic [15:0]         imm16,
    output logic [25:0]         target26,
    output logic                fetch_error
);

    localparam int CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    fetch_state_t  r_state;
    logic [31:0]   r_addr;
    logic [31:0]   r_instr;
    logic [CW-1:0] r_count;
    logic          r_error;
    logic [31:0]   w_rdata;
    logic          w_timeout;

    assign w_rdata   = ENDIAN_SWAP ? byte_swap(avm.avm_readdata) : avm.avm_readdata;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_count == TO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_addr  <= '0;
            r_instr <= '0;
            r_count <= '0;
            r_error <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (fetch_req) begin
                        if (pc[1:0] == 2'b00) begin
                            r_addr  <= pc;
                            r_count <= '0;
                            r_state <= ST_REQ;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= ST_HALT;
                        end
                    end
                end
                ST_REQ: begin
                    // A completing read wins over a timeout in the same cycle.
                    if (!avm.avm_waitrequest) begin
                        r_instr <= w_rdata;
                        r_state <= ST_DONE;
                    end else if (w_timeout) begin
                        r_error <= 1'b1;
                        r_state <= ST_HALT;
                    end else if (r_count != '1) begin
                        r_count <= r_count + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign avm.avm_address    = r_addr;
    assign avm.avm_read       = (r_state == ST_REQ);
    assign avm.avm_byteenable = (r_state == ST_REQ) ? 4'b1111 : 4'b0000;

    assign stall       = ((r_state == ST_IDLE) && fetch_req) || (r_state == ST_REQ) || (r_state == ST_HALT);
    assign instr_valid = (r_state == ST_DONE);
    assign fetch_error = r_error;

    assign instr    = r_instr;
    assign opcode   = r_instr[31:26];
    assign rs       = r_instr[25:21];
    assign rt       = r_instr[20:16];
    assign rd       = r_instr[15:11];
    assign shamt    = r_instr[10:6];
    assign funct    = r_instr[5:0];
    assign imm16    = r_instr[15:0];
    assign target26 = r_instr[25:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: default, short-timeout and byte-swap instances.
module tb_instruction_fetch;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Per-instance stimulus and observation (0 = default, t = timeout 4, s = swap).
    logic [31:0] pc0, pcT, pcS;
    logic        fr0, frT, frS;
    logic        st0, stT, stS;
    logic [31:0] in0, inT, inS;
    logic        iv0, ivT, ivS;
    logic        er0, erT, erS;
    logic [5:0]  op0, opT, opS, fn0, fnT, fnS;
    logic [4:0]  rs0, rsT, rsS, rt0, rtT, rtS, rd0, rdT, rdS, sh0, shT, shS;
    logic [15:0] im0, imT, imS;
    logic [25:0] tg0, tgT, tgS;

    instruction_fetch_if if0 ();
    instruction_fetch_if ifT ();
    instruction_fetch_if ifS ();

    instruction_fetch dut0 (
        .clk(clk), .rst(rst), .pc(pc0), .fetch_req(fr0), .avm(if0.master),
        .stall(st0), .instr(in0), .instr_valid(iv0), .opcode(op0), .rs(rs0),
        .rt(rt0), .rd(rd0), .shamt(sh0), .funct(fn0), .imm16(im0),
        .target26(tg0), .fetch_error(er0)
    );

    instruction_fetch #(.TIMEOUT_CYCLES(4)) dutT (
        .clk(clk), .rst(rst), .pc(pcT), .fetch_req(frT), .avm(ifT.master),
        .stall(stT), .instr(inT), .instr_valid(ivT), .opcode(opT), .rs(rsT),
        .rt(rtT), .rd(rdT), .shamt(shT), .funct(fnT), .imm16(imT),
        .target26(tgT), .fetch_error(erT)
    );

    instruction_fetch #(.ENDIAN_SWAP(1'b1)) dutS (
        .clk(clk), .rst(rst), .pc(pcS), .fetch_req(frS), .avm(ifS.master),
        .stall(stS), .instr(inS), .instr_valid(ivS), .opcode(opS), .rs(rsS),
        .rt(rtS), .rd(rdS), .shamt(shS), .funct(fnS), .imm16(imS),
        .target26(tgS), .fetch_error(erS)
    );

    initial begin
        pc0 = '0; pcT = '0; pcS = '0;
        fr0 = 1'b0; frT = 1'b0; frS = 1'b0;
        if0.avm_waitrequest = 1'b0; if0.avm_readdata = '0;
        ifT.avm_waitrequest = 1'b0; ifT.avm_readdata = '0;
        ifS.avm_waitrequest = 1'b0; ifS.avm_readdata = '0;

        // Reset state
        tick(); tick();
        chk("rst_instr", in0, 32'h0);
        chk("rst_addr", if0.avm_address, 32'h0);
        chk("rst_read", {31'b0, if0.avm_read}, 32'h0);
        chk("rst_be", {28'b0, if0.avm_byteenable}, 32'h0);
        chk("rst_valid", {31'b0, iv0}, 32'h0);
        chk("rst_err", {31'b0, er0}, 32'h0);
        chk("rst_stall_lo", {31'b0, st0}, 32'h0);
        fr0 = 1'b1; #1;
        chk("rst_stall_hi", {31'b0, st0}, 32'h1);
        fr0 = 1'b0;
        rst = 1'b1;

        // Zero-wait fetch: J 4 at 0x10
        tick();
        pc0 = 32'h10; fr0 = 1'b1; #1;
        chk("zw_c0_stall", {31'b0, st0}, 32'h1);
        chk("zw_c0_read", {31'b0, if0.avm_read}, 32'h0);
        tick();
        if0.avm_waitrequest = 1'b0; if0.avm_readdata = 32'h0800_0004; #1;
        chk("zw_c1_read", {31'b0, if0.avm_read}, 32'h1);
        chk("zw_c1_addr", if0.avm_address, 32'h10);
        chk("zw_c1_be", {28'b0, if0.avm_byteenable}, 32'hF);
        chk("zw_c1_stall", {31'b0, st0}, 32'h1);
        tick();
        fr0 = 1'b0; #1;
        chk("zw_c2_valid", {31'b0, iv0}, 32'h1);
        chk("zw_c2_instr", in0, 32'h0800_0004);
        chk("zw_c2_opcode", {26'b0, op0}, {26'b0, OP_J});
        chk("zw_c2_target", {6'b0, tg0}, 32'h4);
        chk("zw_c2_stall", {31'b0, st0}, 32'h0);
        chk("zw_c2_read", {31'b0, if0.avm_read}, 32'h0);
        tick();
        chk("zw_c3_valid", {31'b0, iv0}, 32'h0);
        chk("zw_c3_instr", in0, 32'h0800_0004);

        // Three waitrequest cycles; fetch_req drops mid-read
        pc0 = 32'h14; fr0 = 1'b1;
        if0.avm_waitrequest = 1'b1; if0.avm_readdata = 32'hDEAD_BEEF;
        tick();
        fr0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("ws_read", {31'b0, if0.avm_read}, 32'h1);
            chk("ws_addr", if0.avm_address, 32'h14);
            chk("ws_stall", {31'b0, st0}, 32'h1);
            chk("ws_instr_hold", in0, 32'h0800_0004);
            chk("ws_valid", {31'b0, iv0}, 32'h0);
            tick();
        end
        if0.avm_waitrequest = 1'b0; if0.avm_readdata = 32'h0085_1020; #1;
        chk("ws_c4_read", {31'b0, if0.avm_read}, 32'h1);
        chk("ws_c4_addr", if0.avm_address, 32'h14);
        chk("ws_c4_instr", in0, 32'h0800_0004);
        tick();
        chk("ws_c5_valid", {31'b0, iv0}, 32'h1);
        chk("ws_c5_instr", in0, 32'h0085_1020);
        chk("ws_rs", {27'b0, rs0}, 32'd4);
        chk("ws_rt", {27'b0, rt0}, 32'd5);
        chk("ws_rd", {27'b0, rd0}, 32'd2);
        chk("ws_shamt", {27'b0, sh0}, 32'd0);
        chk("ws_funct", {26'b0, fn0}, 32'h20);
        chk("ws_stall", {31'b0, st0}, 32'h0);

        // Reset during REQ, then a fresh fetch
        tick();
        pc0 = 32'h20; fr0 = 1'b1; if0.avm_waitrequest = 1'b1;
        tick();
        chk("mr_read_before", {31'b0, if0.avm_read}, 32'h1);
        rst = 1'b0; #1;
        chk("mr_read", {31'b0, if0.avm_read}, 32'h0);
        chk("mr_addr", if0.avm_address, 32'h0);
        chk("mr_be", {28'b0, if0.avm_byteenable}, 32'h0);
        chk("mr_instr", in0, 32'h0);
        chk("mr_err", {31'b0, er0}, 32'h0);
        chk("mr_stall", {31'b0, st0}, 32'h1);
        tick();
        rst = 1'b1;
        if0.avm_waitrequest = 1'b0; if0.avm_readdata = 32'h1043_0003;
        tick();
        chk("fr_read", {31'b0, if0.avm_read}, 32'h1);
        chk("fr_addr", if0.avm_address, 32'h20);
        tick();
        fr0 = 1'b0; #1;
        chk("fr_valid", {31'b0, iv0}, 32'h1);
        chk("fr_instr", in0, 32'h1043_0003);
        chk("fr_opcode", {26'b0, op0}, {26'b0, OP_BEQ});
        chk("fr_rs", {27'b0, rs0}, 32'd2);
        chk("fr_rt", {27'b0, rt0}, 32'd3);
        chk("fr_imm", {16'b0, im0}, 32'h3);

        // Misaligned PC
        tick();
        pc0 = 32'h6; fr0 = 1'b1; #1;
        chk("ma_c0_stall", {31'b0, st0}, 32'h1);
        tick();
        fr0 = 1'b0; #1;
        chk("ma_err", {31'b0, er0}, 32'h1);
        chk("ma_read", {31'b0, if0.avm_read}, 32'h0);
        chk("ma_stall", {31'b0, st0}, 32'h1);
        chk("ma_instr", in0, 32'h1043_0003);
        repeat (3) tick();
        chk("ma_halt_stall", {31'b0, st0}, 32'h1);
        chk("ma_halt_read", {31'b0, if0.avm_read}, 32'h0);
        chk("ma_halt_err", {31'b0, er0}, 32'h1);
        rst = 1'b0; #1;
        chk("ma_rst_err", {31'b0, er0}, 32'h0);
        chk("ma_rst_stall", {31'b0, st0}, 32'h0);
        tick();
        rst = 1'b1;

        // Timeout after 4 stuck REQ cycles
        pcT = 32'h40; frT = 1'b1; ifT.avm_waitrequest = 1'b1;
        tick();
        frT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_read", {31'b0, ifT.avm_read}, 32'h1);
            chk("to_stall", {31'b0, stT}, 32'h1);
            chk("to_err_lo", {31'b0, erT}, 32'h0);
            tick();
        end
        chk("to_read_drop", {31'b0, ifT.avm_read}, 32'h0);
        chk("to_err", {31'b0, erT}, 32'h1);
        chk("to_stall_halt", {31'b0, stT}, 32'h1);
        ifT.avm_waitrequest = 1'b0; ifT.avm_readdata = 32'hCAFE_F00D;
        repeat (4) tick();
        chk("to_halt_read", {31'b0, ifT.avm_read}, 32'h0);
        chk("to_halt_err", {31'b0, erT}, 32'h1);
        chk("to_halt_valid", {31'b0, ivT}, 32'h0);
        chk("to_instr", inT, 32'h0);
        rst = 1'b0; #1;
        chk("to_rst_err", {31'b0, erT}, 32'h0);
        chk("to_rst_stall", {31'b0, stT}, 32'h0);
        tick();
        rst = 1'b1;

        // Byte-swapped capture
        pcS = 32'h100; frS = 1'b1;
        ifS.avm_waitrequest = 1'b0; ifS.avm_readdata = 32'h1234_5678;
        tick();
        chk("sw_read", {31'b0, ifS.avm_read}, 32'h1);
        chk("sw_addr", ifS.avm_address, 32'h100);
        tick();
        frS = 1'b0; #1;
        chk("sw_valid", {31'b0, ivS}, 32'h1);
        chk("sw_instr", inS, 32'h7856_3412);
        chk("sw_stall", {31'b0, stS}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
